// File: rtl/dcim_pkg.sv
// Shared widths and types for the DCIM SRAM-multiplier system and its
// downstream sweep accumulator.
package dcim_pkg;

    localparam int PROD_WIDTH = 64;
    localparam int ADDR_COUNT = 64;
    localparam int ADDR_WIDTH = $clog2(ADDR_COUNT);
    localparam int ACC_WIDTH  = PROD_WIDTH + ADDR_WIDTH;
    localparam int FIFO_DEPTH = 4;

    typedef logic [PROD_WIDTH-1:0] prod_t;
    typedef logic [ACC_WIDTH-1:0]  acc_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(ADDR_COUNT - 1);

    // Products are unsigned, so widening is a plain zero-extension.
    function automatic acc_t widen(input prod_t p);
        return ACC_WIDTH'(p);
    endfunction

endpackage

// File: rtl/dcim_result_fifo.sv
// Small result FIFO with a registered head. Full/empty come from pointers
// carrying an extra wrap bit; push and pop in the same cycle are legal.
module dcim_result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             full,
    output logic             drop
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]      wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] head_q;
    logic             empty, pop, push_ok;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) && (wr_ptr[PW] != rd_ptr[PW]);
    assign pop      = !empty && pop_ready;
    // Pop-then-push: a full FIFO still accepts when the head leaves this cycle.
    assign push_ok  = push && (!full || pop);
    assign drop     = push && !push_ok;
    assign wr_ptr_n = wr_ptr + (PW+1)'(push_ok);
    assign rd_ptr_n = rd_ptr + (PW+1)'(pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[PW-1:0]] <= push_data;
        end
    end

    // The head register tracks mem[rd_ptr], bypassing the write when the
    // incoming word becomes the only entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            head_q <= '0;
        end else begin
            wr_ptr <= wr_ptr_n;
            rd_ptr <= rd_ptr_n;
            if (wr_ptr_n == rd_ptr_n) begin
                head_q <= '0;
            end else if (push_ok && (wr_ptr[PW-1:0] == rd_ptr_n[PW-1:0])) begin
                head_q <= push_data;
            end else begin
                head_q <= mem[rd_ptr_n[PW-1:0]];
            end
        end
    end

    assign out_valid = !empty;
    assign out_data  = head_q;

endmodule

// File: rtl/dcim_sweep_accumulator.sv
// Sums one full SRAM sweep of multiplier products into a dot-product result
// and queues completed results behind a valid/ready output.
module dcim_sweep_accumulator
    import dcim_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  in_valid,
    input  logic [PROD_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  out_sum,
    output logic [ADDR_WIDTH-1:0] sweep_idx,
    output logic                  drop_err
);

    // Handshake: a result transfers on any rising edge where out_valid and
    // out_ready are both high; out_sum holds while out_valid && !out_ready.
    // The input side has no ready and absorbs every in_valid strobe.

    acc_t                  acc;
    logic [ADDR_WIDTH-1:0] idx;
    acc_t                  sum_next;
    logic                  last;
    logic                  fifo_full;
    logic                  fifo_drop;

    assign sum_next = acc + widen(in_data);
    assign last     = in_valid && !clear && (idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc      <= '0;
            idx      <= '0;
            drop_err <= 1'b0;
        end else begin
            if (clear) begin
                acc <= '0;
                idx <= '0;
            end else if (in_valid) begin
                if (last) begin
                    acc <= '0;
                    idx <= '0;
                end else begin
                    acc <= sum_next;
                    idx <= idx + ADDR_WIDTH'(1);
                end
            end
            if (fifo_drop) begin
                drop_err <= 1'b1;
            end
        end
    end

    assign sweep_idx = idx;

    dcim_result_fifo #(
        .WIDTH (ACC_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (last),
        .push_data (sum_next),
        .pop_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_sum),
        .full      (fifo_full),
        .drop      (fifo_drop)
    );

endmodule

// File: tb/tb_dcim_sweep_accumulator.sv
// Self-checking bench for dcim_sweep_accumulator: sweep table, scoreboard
// on the result stream, and hand-written corner-case sequences.
module tb_dcim_sweep_accumulator;
    import dcim_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  clear;
    logic                  in_valid;
    prod_t                 in_data;
    logic                  out_valid;
    logic                  out_ready;
    acc_t                  out_sum;
    logic [ADDR_WIDTH-1:0] sweep_idx;
    logic                  drop_err;

    dcim_sweep_accumulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .sweep_idx (sweep_idx),
        .drop_err  (drop_err)
    );

    always #5 clk = ~clk;

    acc_t exp_q[$];
    acc_t m_acc;
    int   m_idx;
    logic exp_drop;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_pop    = 0;

    typedef struct {
        prod_t base;
        prod_t step;
        acc_t  exp_sum;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input acc_t act, input acc_t exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Drives one product for one cycle and updates the reference sweep model.
    task automatic drive_product(input prod_t d);
        acc_t r;
        in_valid = 1'b1;
        in_data  = d;
        clear    = 1'b0;
        if (m_idx == ADDR_COUNT - 1) begin
            r = m_acc + acc_t'(d);
            if (exp_q.size() < FIFO_DEPTH || out_ready) exp_q.push_back(r);
            else exp_drop = 1'b1;
            m_acc = '0;
            m_idx = 0;
        end else begin
            m_acc = m_acc + acc_t'(d);
            m_idx++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle_gap(input int gap_max);
        int g;
        g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        if (g > 0) begin
            repeat (g) @(posedge clk);
            #1;
        end
    endtask

    task automatic run_sweep(input prod_t base, input prod_t step, input int gap_max);
        for (int k = 0; k < ADDR_COUNT; k++) begin
            drive_product(base + prod_t'(k) * step);
            idle_gap(gap_max);
        end
    endtask

    task automatic run_rand_sweep(input int gap_max);
        for (int k = 0; k < ADDR_COUNT; k++) begin
            drive_product({$urandom(), $urandom()});
            idle_gap(gap_max);
        end
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        clear    = 1'b0;
        exp_q.delete();
        m_acc    = '0;
        m_idx    = 0;
        exp_drop = 1'b0;
        @(posedge clk);
        #1;
        check("rst_out_valid", acc_t'(out_valid), '0);
        check("rst_out_sum", out_sum, '0);
        check("rst_sweep_idx", acc_t'(sweep_idx), '0);
        check("rst_drop_err", acc_t'(drop_err), '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(input int max_cycles);
        int c;
        c = 0;
        while (exp_q.size() > 0 && c < max_cycles) begin
            @(posedge clk);
            c++;
        end
        #1;
        check("drain_pending", acc_t'(exp_q.size()), '0);
        check("drain_out_valid", acc_t'(out_valid), '0);
    endtask

    // Scoreboard: every accepted output transfer must match the queue head.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_out: got %0d, expected no result", out_sum);
            end else begin
                check("out_sum", out_sum, exp_q.pop_front());
            end
            n_pop++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        vecs[0] = '{base: 64'd1, step: 64'd0, exp_sum: 70'd64};
        vecs[1] = '{base: 64'hFFFF_FFFF_FFFF_FFFF, step: 64'd0, exp_sum: 70'h3F_FFFF_FFFF_FFFF_FFC0};
        vecs[2] = '{base: 64'd0, step: 64'd1, exp_sum: 70'd2016};
        vecs[3] = '{base: 64'd5, step: 64'd3, exp_sum: 70'd6368};
        vecs[4] = '{base: 64'h8000_0000_0000_0000, step: 64'd0, exp_sum: 70'h20_0000_0000_0000_0000};

        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        m_acc     = '0;
        m_idx     = 0;
        exp_drop  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        apply_reset();

        // Single sweep of ones: exact one-cycle latency and index wrap.
        out_ready = 1'b1;
        for (int k = 0; k < ADDR_COUNT - 1; k++) drive_product(64'd1);
        check("pre_last_valid", acc_t'(out_valid), '0);
        check("pre_last_idx", acc_t'(sweep_idx), acc_t'(63));
        drive_product(64'd1);
        check("latency_valid", acc_t'(out_valid), acc_t'(1));
        check("latency_sum", out_sum, 70'd64);
        check("wrap_idx", acc_t'(sweep_idx), '0);
        wait_drain(10);

        // Table of sweeps with hand-computed dot products.
        for (int v = 0; v < 5; v++) begin
            out_ready = 1'b0;
            run_sweep(vecs[v].base, vecs[v].step, 0);
            check("table_valid", acc_t'(out_valid), acc_t'(1));
            check("table_sum", out_sum, vecs[v].exp_sum);
            out_ready = 1'b1;
            wait_drain(10);
        end

        // Three back-to-back random sweeps with random input gaps.
        out_ready = 1'b1;
        for (int s = 0; s < 3; s++) run_rand_sweep(3);
        wait_drain(50);

        // Five sweeps with the consumer stalled: four kept, one dropped.
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) run_sweep(64'd1, 64'd0, 0);
        check("ovf_drop_err", acc_t'(drop_err), acc_t'(1));
        check("ovf_drop_model", acc_t'(drop_err), acc_t'(exp_drop));
        check("ovf_valid", acc_t'(out_valid), acc_t'(1));
        n0 = n_pop;
        out_ready = 1'b1;
        wait_drain(20);
        check("ovf_drain_count", acc_t'(n_pop - n0), acc_t'(4));
        check("ovf_drop_sticky", acc_t'(drop_err), acc_t'(1));

        // Push and pop on the same edge while full.
        apply_reset();
        out_ready = 1'b0;
        for (int s = 1; s <= 4; s++) run_sweep(prod_t'(s), 64'd0, 0);
        for (int k = 0; k < ADDR_COUNT - 1; k++) drive_product(64'd5);
        out_ready = 1'b1;
        n0 = n_pop;
        drive_product(64'd5);
        check("full_pp_drop_err", acc_t'(drop_err), '0);
        wait_drain(20);
        check("full_pp_count", acc_t'(n_pop - n0), acc_t'(5));
        check("full_pp_drop_after", acc_t'(drop_err), '0);

        // Reset in the middle of a sweep discards the partial sum.
        out_ready = 1'b0;
        for (int k = 0; k < 30; k++) drive_product(64'd1);
        check("mid_idx", acc_t'(sweep_idx), acc_t'(30));
        apply_reset();
        run_sweep(64'd1, 64'd0, 0);
        check("post_rst_sum", out_sum, 70'd64);
        out_ready = 1'b1;
        wait_drain(10);

        // Clear mid-sweep with a simultaneous product; queued results survive.
        out_ready = 1'b0;
        run_sweep(64'd2, 64'd0, 0);
        for (int k = 0; k < 30; k++) drive_product(64'd1);
        in_valid = 1'b1;
        in_data  = 64'd7;
        clear    = 1'b1;
        m_acc    = '0;
        m_idx    = 0;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clear_idx", acc_t'(sweep_idx), '0);
        check("clear_keep_valid", acc_t'(out_valid), acc_t'(1));
        check("clear_keep_sum", out_sum, 70'd128);
        run_sweep(64'd1, 64'd0, 0);
        n0 = n_pop;
        out_ready = 1'b1;
        wait_drain(10);
        check("clear_drain_count", acc_t'(n_pop - n0), acc_t'(2));
        check("clear_drop_err", acc_t'(drop_err), '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
